// File: rtl/dmem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dmem_ctrl : data-memory controller, byte/halfword/word access    |
// | Optional wait states via macro DMEM_WAIT_EN.   Revision: 1.0      |
// +------------------------------------------------------------------+
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 16384,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] DAD,
  inout  wire  [31:0] DDT,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  output logic        ACKD_n
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rd_word;
  logic [31:0]       rd_data;
  logic [31:0]       wr_data;
  logic [3:0]        byte_en;
  logic              misaligned;
  logic              ack_raw;
  logic              ack;
  logic              unused_ok;

  // Upper address bits wrap; they only feed this sink.
  assign unused_ok = ^{DAD[31:ADDR_W+2], 4'(WAIT_CYCLES)};

  assign idx     = DAD[ADDR_W+1:2];
  assign rd_word = mem[idx];

  always_comb begin
    misaligned = 1'b0;
    rd_data    = '0;
    wr_data    = '0;
    byte_en    = '0;
    case (SIZE)
      2'b00: begin
        rd_data = {24'h0, rd_word[{DAD[1:0], 3'b000} +: 8]};
        wr_data = {4{DDT[7:0]}};
        byte_en = 4'b0001 << DAD[1:0];
      end
      2'b01: begin
        misaligned = DAD[0];
        rd_data    = {16'h0, rd_word[{DAD[1], 4'h0} +: 16]};
        wr_data    = {2{DDT[15:0]}};
        byte_en    = DAD[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        misaligned = |DAD[1:0];
        rd_data    = rd_word;
        wr_data    = DDT;
        byte_en    = 4'b1111;
      end
    endcase
    if (misaligned) begin
      rd_data = '0;
      byte_en = '0;
    end
  end

`ifdef DMEM_WAIT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // WAIT leaves as the counter decrements to zero, so the ACK cycle
  // lands exactly WAIT_N cycles after the request cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_raw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (MREQ) begin
          if (WAIT_N == 4'd0) begin
            ack_raw = 1'b1;
          end else begin
            cnt_d   = WAIT_N - 4'd1;
            state_d = (WAIT_N == 4'd1) ? ST_ACK : ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!MREQ) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d = ST_ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        ack_raw = MREQ;
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end
`else
  assign ack_raw = MREQ;
`endif

  assign ack    = rst_n & ack_raw;
  assign ACKD_n = ~ack;
  assign DDT    = (rst_n && MREQ && !WRITE) ? rd_data : {32{1'bz}};

  // Contents survive reset; a write needs an acknowledge, which reset masks.
  always_ff @(posedge clk) begin
    if (ack && WRITE) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dmem_ctrl : self-checking bench for dmem_ctrl                 |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_dmem_ctrl;

  localparam int WAIT_P = 2;
  localparam int DEPTH  = 16;
`ifdef DMEM_WAIT_EN
  localparam int EXP_N = WAIT_P;
`else
  localparam int EXP_N = 0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        mreq  = 1'b0;
  logic        wr    = 1'b0;
  logic        oe    = 1'b0;
  logic [1:0]  sz    = 2'b00;
  logic [31:0] dad   = 32'h0;
  logic [31:0] drv   = 32'h0;
  wire  [31:0] ddt;
  wire         ackd_n;

  assign ddt = oe ? drv : {32{1'bz}};
  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_P)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .DAD    (dad),
    .DDT    (ddt),
    .MREQ   (mreq),
    .WRITE  (wr),
    .SIZE   (sz),
    .ACKD_n (ackd_n)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [DEPTH];

  typedef struct {
    logic        w;
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] s, input logic [31:0] a);
    logic [31:0] w;
    w = model[(a / 4) % DEPTH];
    if (s == 2'b00) return (w >> (8 * (a % 4))) & 32'hFF;
    if (s == 2'b01) return (a % 2 != 0) ? 32'h0 : ((w >> (8 * (a % 4))) & 32'hFFFF);
    return (a % 4 != 0) ? 32'h0 : w;
  endfunction

  function automatic void model_write(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    int          i;
    int          sh;
    logic [31:0] m;
    i  = int'((a / 4) % DEPTH);
    sh = int'(8 * (a % 4));
    if (s == 2'b00) m = 32'hFF;
    else if (s == 2'b01) begin
      if (a % 2 != 0) return;
      m = 32'hFFFF;
    end else begin
      if (a % 4 != 0) return;
      m = 32'hFFFF_FFFF;
    end
    model[i] = (model[i] & ~(m << sh)) | ((d & m) << sh);
  endfunction

  // One access with MREQ held until acknowledged; returns ack cycle (0 = none).
  task automatic access(input logic w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d, output int ack_cyc, output logic [31:0] rd);
    ack_cyc = 0;
    rd      = 32'h0;
    mreq = 1'b1; wr = w; sz = s; dad = a; drv = d; oe = w;
    for (int c = 1; c <= EXP_N + 8; c++) begin
      @(negedge clk);
      if (ack_cyc == 0 && ackd_n == 1'b0) begin
        ack_cyc = c;
        rd      = ddt;
      end
      @(posedge clk);
      #1;
      if (ack_cyc != 0) break;
    end
    mreq = 1'b0;
    oe   = 1'b0;
  endtask

  task automatic do_vec(input string name, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
    int          cyc;
    logic [31:0] rd;
    access(w, s, a, d, cyc, rd);
    check({name, "_ack_cycle"}, 32'(cyc), 32'(EXP_N + 1));
    if (w) model_write(s, a, d);
    else   check({name, "_rdata"}, rd, e);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'b10, 32'h100, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b0, 2'b10, 32'h100, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b1, 2'b00, 32'h102, 32'h123456AA, 32'h0};
    tbl[3]  = '{1'b0, 2'b10, 32'h100, 32'h0,        32'hDEAABEEF};
    tbl[4]  = '{1'b0, 2'b00, 32'h103, 32'h0,        32'h000000DE};
    tbl[5]  = '{1'b1, 2'b01, 32'h101, 32'h00001234, 32'h0};
    tbl[6]  = '{1'b0, 2'b10, 32'h100, 32'h0,        32'hDEAABEEF};
    tbl[7]  = '{1'b0, 2'b01, 32'h101, 32'h0,        32'h0};
    tbl[8]  = '{1'b1, 2'b10, 32'h104, 32'h11223344, 32'h0};
    tbl[9]  = '{1'b1, 2'b01, 32'h106, 32'h9999CAFE, 32'h0};
    tbl[10] = '{1'b0, 2'b10, 32'h104, 32'h0,        32'hCAFE3344};
    tbl[11] = '{1'b0, 2'b01, 32'h104, 32'h0,        32'h00003344};
    tbl[12] = '{1'b0, 2'b11, 32'h104, 32'h0,        32'hCAFE3344};
    tbl[13] = '{1'b0, 2'b10, 32'h105, 32'h0,        32'h0};
    tbl[14] = '{1'b1, 2'b10, 32'h040, 32'h55667788, 32'h0};
    tbl[15] = '{1'b0, 2'b10, 32'h000, 32'h0,        32'h55667788};
    tbl[16] = '{1'b0, 2'b00, 32'h002, 32'h0,        32'h00000066};
    tbl[17] = '{1'b1, 2'b10, 32'h103, 32'hAAAAAAAA, 32'h0};
    tbl[18] = '{1'b0, 2'b10, 32'h100, 32'h0,        32'h55667788};
    tbl[19] = '{1'b0, 2'b00, 32'h105, 32'h0,        32'h00000033};
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    // Reset holds the acknowledge off even with a request pending.
    mreq = 1'b1;
    @(negedge clk);
    check("reset_ackd_n", {31'h0, ackd_n}, 32'h1);
    @(posedge clk);
    #1;
    mreq  = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      do_vec($sformatf("vec%0d", i), tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d, tbl[i].e);
    end

`ifdef DMEM_WAIT_EN
    // Request dropped after WAIT_P cycles: lands in ACK with MREQ low.
    mreq = 1'b1; wr = 1'b1; sz = 2'b10; dad = 32'h100; drv = 32'h0BADF00D; oe = 1'b1;
    for (int c = 1; c <= WAIT_P; c++) begin
      @(negedge clk);
      check($sformatf("abort_cyc%0d", c), {31'h0, ackd_n}, 32'h1);
      @(posedge clk);
      #1;
    end
    mreq = 1'b0;
    oe   = 1'b0;
    @(negedge clk);
    check("abort_in_ack", {31'h0, ackd_n}, 32'h1);
    @(posedge clk);
    #1;
    do_vec("after_abort", 1'b0, 2'b10, 32'h100, 32'h0, model_read(2'b10, 32'h100));
`endif

    // Reset asserted while a write is in flight.
    mreq = 1'b1; wr = 1'b1; sz = 2'b10; dad = 32'h104; drv = 32'hFEEDFACE; oe = 1'b1;
    repeat ((EXP_N > 1) ? 1 : 0) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_ackd_n", {31'h0, ackd_n}, 32'h1);
    @(posedge clk);
    #1;
    check("midreset_hold", {31'h0, ackd_n}, 32'h1);
    mreq  = 1'b0;
    oe    = 1'b0;
    rst_n = 1'b1;
    do_vec("after_reset", 1'b0, 2'b10, 32'h104, 32'h0, model_read(2'b10, 32'h104));

    for (int i = 0; i < DEPTH; i++) begin
      do_vec($sformatf("init%0d", i), 1'b1, 2'b10, 32'(4 * i), $urandom, 32'h0);
    end

    for (int n = 0; n < 300; n++) begin
      logic        w;
      logic [1:0]  s;
      logic [31:0] a;
      w = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      a = $urandom;
      do_vec($sformatf("rnd%0d", n), w, s, a, $urandom, model_read(s, a));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 16384; number of 32-bit words; power of two.
REQ-002 Parameter WAIT_CYCLES, default 2; wait states per access, range 0..15; used only when DMEM_WAIT_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 DAD  input  32  byte address from the processor MEM stage.
REQ-006 DDT  inout  32  data bus; the block drives it only during reads, else high-Z.
REQ-007 MREQ  input  1  access request; 1 = access.
REQ-008 WRITE  input  1  1 = write, 0 = read; valid while MREQ=1.
REQ-009 SIZE  input  2  access size: 2'b00 byte, 2'b01 halfword, 2'b10 word; 2'b11 treated as word.
REQ-010 ACKD_n  output  1  acknowledge, active-low; 0 = access completes this cycle.

Function
REQ-011 Storage SHALL be DEPTH_WORDS x 32 bits, indexed by DAD[log2(DEPTH_WORDS)+1:2]; upper address bits ignored (wrap-around).
REQ-012 Lane select: byte = DAD[1:0]; halfword = DAD[1]; word = full word.
REQ-013 Read data SHALL be right-justified and zero-extended: byte to bits [7:0], halfword to [15:0]; sign extension is the processor's job.
REQ-014 Write data SHALL be taken from DDT[7:0], DDT[15:0] or DDT[31:0] per SIZE and stored only into the selected lanes; other lanes are unchanged.
REQ-015 Misaligned access (halfword with DAD[0]=1, word with DAD[1:0]!=0): write suppressed, read returns 32'h0, ACKD_n still asserted on schedule.
REQ-016 DDT SHALL be driven iff MREQ=1 and WRITE=0; read data is valid whenever ACKD_n=0.
REQ-017 FSM states: IDLE, WAIT, ACK.
REQ-018 IDLE, MREQ=0: ACKD_n=1, no action.
REQ-019 IDLE, MREQ=1, effective wait count 0: ACKD_n=0 combinationally in the same cycle; a write commits at that cycle's rising edge; stay in IDLE.
REQ-020 IDLE, MREQ=1, wait count N>0: ACKD_n=1; counter loads N-1; next state WAIT.
REQ-021 WAIT: ACKD_n=1; counter decrements; when the counter is 0, next state ACK.
REQ-022 ACK: ACKD_n=0 for exactly one cycle; a write commits at the edge leaving ACK; next state IDLE.
REQ-023 An access with N waits therefore gives ACKD_n=0 in cycle N+1, counting the request cycle as cycle 1.
REQ-024 MREQ falling in WAIT or ACK SHALL abort the access: next state IDLE, no write, ACKD_n=1.
REQ-025 Back-to-back: with MREQ held after ACK, the cycle following ACK is IDLE and a new access starts there.
REQ-026 Address, WRITE and SIZE SHALL be sampled when ACKD_n=0; the block does not latch them at request time.

Reset
REQ-027 rst_n=0 SHALL force IDLE and counter=0 immediately, with ACKD_n=1 and DDT high-Z.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 Reset asserted mid-access SHALL abort the access with no write.
REQ-030 After rst_n deasserts, the first access SHALL start from IDLE.

Configuration
REQ-031 Macro DMEM_WAIT_EN: when defined, the wait count is WAIT_CYCLES.
REQ-032 When DMEM_WAIT_EN is undefined, the wait count is 0, the counter and the WAIT and ACK states are not synthesized, and every access is acknowledged per REQ-019.

Verification
REQ-033 WAIT_CYCLES=2, DMEM_WAIT_EN defined: word write DAD=0x100, DDT=0xDEADBEEF, MREQ held -> ACKD_n=1,1,0 in cycles 1-3; then word read 0x100 -> DDT=0xDEADBEEF with ACKD_n=0 in cycle 3.
REQ-034 Preload 0x100=0xDEADBEEF: byte write DAD=0x102, DDT=0x000000AA -> word read returns 0xDEAABEEF; byte read 0x103 returns 0x000000DE.
REQ-035 Halfword write DAD=0x101, DDT=0x1234 -> ACKD_n=0 on schedule, memory unchanged; halfword read 0x101 returns 0x00000000.
REQ-036 WAIT_CYCLES=3: MREQ=1 for 2 cycles then 0 -> ACKD_n never 0, no write; rst_n pulsed low in the WAIT state -> ACKD_n=1 at once, state IDLE, memory intact.
REQ-037 DMEM_WAIT_EN undefined: word read 0x100 -> ACKD_n=0 in the request cycle; DEPTH_WORDS=16, write DAD=0x40 -> data readable at DAD=0x0 (wrap-around).
